// File: rtl/mem_pkg.sv
// Shared types and widths for the cache-to-memory line protocol responder.
package mem_pkg;

    localparam int unsigned LINE_W     = 128;
    localparam int unsigned MEM_ADDR_W = 28;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/mem_line_array.sv
// Single-port line storage: synchronous write, registered read that holds between reads.
module mem_line_array
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    // Storage is deliberately not reset so contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/slow_mem_responder.sv
// Slow main-memory responder: one request at a time, fixed latency, one-cycle ready pulse.
module slow_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = 8,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic                  clk,
    input  logic                  proc_reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]     mem_wdata,
    output logic [LINE_W-1:0]     mem_rdata,
    output logic                  mem_ready,
    output logic                  proto_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    op_e                   op_q, op_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]     wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  ready_q;

    logic                  req_c;
    logic                  commit_c;
    logic                  arr_we_c;
    logic                  arr_re_c;

    assign req_c = mem_read | mem_write;

    // Next-state, request latching and protocol checks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (req_c) begin
                    op_d    = mem_write ? OP_WR : OP_RD;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    if (mem_read && mem_write) begin
                        err_d = 1'b1;
                    end
                    if (CNT_LAST == '0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (!req_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (mem_addr != addr_q) begin
                        err_d = 1'b1;
                    end
                    if ((op_q == OP_WR) && (mem_wdata != wdata_q)) begin
                        err_d = 1'b1;
                    end
                    if ((op_q == OP_RD) ? mem_write : mem_read) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The array access happens on the edge that enters RESP; _d values are live in IDLE.
    assign commit_c = (state_d == RESP) && !proc_reset;
    assign arr_we_c = commit_c && (op_d == OP_WR);
    assign arr_re_c = commit_c && (op_d == OP_RD);

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            ready_q <= (state_d == RESP);
        end
    end

    mem_line_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst_i   (proc_reset),
        .we_i    (arr_we_c),
        .re_i    (arr_re_c),
        .addr_i  (addr_d[ADDR_W-1:0]),
        .wdata_i (wdata_d),
        .rdata_o (mem_rdata)
    );

    assign mem_ready = ready_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_slow_mem_responder.sv
// Directed bench for slow_mem_responder at LATENCY=8 and LATENCY=1.
module tb_slow_mem_responder;

    localparam int LAT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst8, rd8, wr8;
    logic [27:0]  addr8;
    logic [127:0] wd8, rdata8;
    logic         ready8, err8;

    logic         rst1, rd1, wr1;
    logic [27:0]  addr1;
    logic [127:0] wd1, rdata1;
    logic         ready1, err1;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] D1  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DAA = {16{8'hAA}};
    localparam logic [127:0] D33 = {16{8'h33}};
    localparam logic [127:0] D55 = {16{8'h55}};
    localparam logic [127:0] D77 = {16{8'h77}};
    localparam logic [127:0] D99 = {16{8'h99}};
    localparam logic [127:0] DBB = {16{8'hBB}};
    localparam logic [127:0] DDE = {8{16'hDEAD}};
    localparam logic [127:0] DC0 = {4{32'hC0FFEE11}};

    slow_mem_responder #(.LATENCY(LAT), .ADDR_W(8)) dut8 (
        .clk        (clk),
        .proc_reset (rst8),
        .mem_read   (rd8),
        .mem_write  (wr8),
        .mem_addr   (addr8),
        .mem_wdata  (wd8),
        .mem_rdata  (rdata8),
        .mem_ready  (ready8),
        .proto_err  (err8)
    );

    slow_mem_responder #(.LATENCY(1), .ADDR_W(8)) dut1 (
        .clk        (clk),
        .proc_reset (rst1),
        .mem_read   (rd1),
        .mem_write  (wr1),
        .mem_addr   (addr1),
        .mem_wdata  (wd1),
        .mem_rdata  (rdata1),
        .mem_ready  (ready1),
        .proto_err  (err1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One LATENCY=8 transaction starting in cycle 0; optional drop and address change.
    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [27:0] a, input logic [127:0] wd,
                       input int drop_at, input int chg_at, input logic [27:0] chg_a,
                       input logic chk_rd, input logic [127:0] exp_rd);
        rd8 = rd; wr8 = wr; addr8 = a; wd8 = wd;
        for (int c = 1; c <= LAT; c++) begin
            tick();
            if (c == drop_at) begin
                rd8 = 1'b0;
                wr8 = 1'b0;
            end
            if (c == chg_at) addr8 = chg_a;
            chk({tag, "_ready"}, 128'(ready8), 128'(c == LAT && drop_at < 0));
        end
        rd8 = 1'b0;
        wr8 = 1'b0;
        if (chk_rd) chk({tag, "_rdata"}, rdata8, exp_rd);
        tick();
        chk({tag, "_ready_after"}, 128'(ready8), 128'(0));
    endtask

    initial begin
        rst8 = 1'b1; rd8 = 1'b0; wr8 = 1'b0; addr8 = '0; wd8 = '0;
        rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
        tick();
        tick();
        rst8 = 1'b0;
        rst1 = 1'b0;
        tick();
        chk("rst_ready8", 128'(ready8), 128'(0));
        chk("rst_rdata8", rdata8, 128'(0));
        chk("rst_err8",   128'(err8),   128'(0));
        chk("rst_ready1", 128'(ready1), 128'(0));
        chk("rst_rdata1", rdata1, 128'(0));
        chk("rst_err1",   128'(err1),   128'(0));

        // LATENCY=1: write, read, then a held read spaced two cycles apart
        wr1 = 1'b1; addr1 = 28'h7; wd1 = DC0;
        tick();
        chk("l1_wr_ready", 128'(ready1), 128'(1));
        wr1 = 1'b0;
        tick();
        chk("l1_wr_idle", 128'(ready1), 128'(0));
        rd1 = 1'b1;
        tick();
        chk("l1_rd_ready_c1", 128'(ready1), 128'(1));
        chk("l1_rd_data", rdata1, DC0);
        tick();
        chk("l1_hold_c2", 128'(ready1), 128'(0));
        tick();
        chk("l1_hold_c3", 128'(ready1), 128'(1));
        rd1 = 1'b0;
        tick();
        chk("l1_hold_c4", 128'(ready1), 128'(0));
        chk("l1_err", 128'(err1), 128'(0));

        // LATENCY=8 basic write/read
        txn("wr10", 1'b0, 1'b1, 28'h0000010, D1, -1, -1, '0, 1'b0, '0);
        txn("rd10", 1'b1, 1'b0, 28'h0000010, '0, -1, -1, '0, 1'b1, D1);

        // Aliasing: 0x105 and 0x005 share line 5
        txn("wr105", 1'b0, 1'b1, 28'h0000105, DAA, -1, -1, '0, 1'b0, '0);
        txn("rd005", 1'b1, 1'b0, 28'h0000005, '0, -1, -1, '0, 1'b1, DAA);

        // Abort: write dropped in cycle 3 leaves prior contents
        txn("wr20", 1'b0, 1'b1, 28'h20, D33, -1, -1, '0, 1'b1, DAA);
        txn("abort20", 1'b0, 1'b1, 28'h20, D55, 3, -1, '0, 1'b1, DAA);
        txn("rd20", 1'b1, 1'b0, 28'h20, '0, -1, -1, '0, 1'b1, D33);
        chk("abort_err", 128'(err8), 128'(0));

        // Protocol errors: read+write together commits as a write
        txn("both30", 1'b1, 1'b1, 28'h30, D77, -1, -1, '0, 1'b0, '0);
        chk("both_err", 128'(err8), 128'(1));
        txn("rd30", 1'b1, 1'b0, 28'h30, '0, -1, -1, '0, 1'b1, D77);

        // Address change mid-WAIT keeps the latched address
        txn("wr41", 1'b0, 1'b1, 28'h41, DBB, -1, -1, '0, 1'b0, '0);
        txn("chg40", 1'b0, 1'b1, 28'h40, D99, -1, 3, 28'h41, 1'b0, '0);
        chk("chg_err", 128'(err8), 128'(1));
        txn("rd40", 1'b1, 1'b0, 28'h40, '0, -1, -1, '0, 1'b1, D99);
        txn("rd41", 1'b1, 1'b0, 28'h41, '0, -1, -1, '0, 1'b1, DBB);

        // Reset in cycle 4 of a write abandons it
        wr8 = 1'b1; addr8 = 28'h10; wd8 = DDE;
        for (int c = 1; c <= 4; c++) tick();
        rst8 = 1'b1;
        #1;
        chk("midrst_ready", 128'(ready8), 128'(0));
        chk("midrst_err",   128'(err8),   128'(0));
        chk("midrst_rdata", rdata8, 128'(0));
        wr8 = 1'b0;
        tick();
        rst8 = 1'b0;
        tick();
        txn("rd10_after_rst", 1'b1, 1'b0, 28'h10, '0, -1, -1, '0, 1'b1, D1);
        chk("final_err", 128'(err8), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slow_mem_responder.md
Name: slow_mem_responder

Overview:
Responder end of the cache-to-memory line protocol (mem_read/mem_write/mem_addr[31:4]/128-bit data/mem_ready). Sits behind either the D-cache or the I-cache and models a slow, multi-cycle main memory holding 128-bit lines. Accepts one request at a time, waits a fixed latency, and then commits the write or returns the read line with a one-cycle mem_ready pulse. Used both in the testbench memory model and as the synthesizable stand-in memory for block-level bring-up.

Parameters:
LATENCY, 8, cycles from request first seen to mem_ready pulse; legal range 1..255
ADDR_W, 8, line-index bits actually decoded from mem_addr; depth = 2**ADDR_W lines (256 lines = 4 KB)

Ports:
clk  input  1  single clock, rising edge
proc_reset  input  1  asynchronous, active-high reset
mem_read  input  1  read-line request, held by cache until mem_ready
mem_write  input  1  write-line request, held by cache until mem_ready
mem_addr  input  28  line address (byte address bits 31:4)
mem_wdata  input  128  write line, valid with mem_write
mem_rdata  output  128  read line, valid in the mem_ready cycle of a read
mem_ready  output  1  one-cycle completion pulse
proto_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async, active-high): state IDLE, mem_ready=0, mem_rdata=0, proto_err=0, counter=0. Array contents are not cleared. Reset mid-transaction abandons it; a pending write is not committed.
- Line index = mem_addr[ADDR_W-1:0]; upper address bits are ignored, so addresses alias and wrap modulo 2**ADDR_W lines.
- FSM states: IDLE, WAIT, RESP. mem_ready is a registered decode of state==RESP.
- IDLE: when mem_read or mem_write is sampled high, latch op, index, full mem_addr and mem_wdata. If LATENCY==1, go to RESP; otherwise go to WAIT with counter=1.
- WAIT: counter increments each cycle. When counter==LATENCY-1, go to RESP.
- Entering RESP (same edge): a read registers array[index] into mem_rdata; a write writes the latched wdata into array[index].
- RESP: mem_ready=1 for exactly one cycle, then go to IDLE unconditionally. A request still high in the following IDLE cycle is treated as a new request.
- Timing: a request first high in cycle 0 produces mem_ready in cycle LATENCY. Back-to-back requests are spaced LATENCY+1 cycles apart (one IDLE cycle between them).
- mem_rdata holds its last value outside RESP and is not updated by writes.
- Abort: if both mem_read and mem_write are low in a WAIT cycle, return to IDLE with no commit and no mem_ready.
- mem_read and mem_write high together at acceptance: set proto_err; treat the request as a write.
- mem_addr or mem_wdata differing from the latched value during WAIT: set proto_err; continue with the latched values.
- Changing op type mid-WAIT (read to write or write to read): set proto_err; continue with the latched op.
- proto_err is cleared only by reset.

Decomposition:
- Shared package mem_pkg:
  - LINE_W=128, MEM_ADDR_W=28
  - state enum {IDLE, WAIT, RESP}
  - op encoding {OP_RD, OP_WR}
- One natural sub-module: mem_line_array, a synchronous single-port 2**ADDR_W x 128 storage with write enable and a registered read. It is instantiated once; the FSM, counter and checks stay in the top.

Test Plan:
- Write then read, LATENCY=8: mem_write=1, addr=0x0000010, wdata=0x0123..CDEF held -> mem_ready high in cycle 8 only. Then mem_read at the same addr -> mem_ready in cycle 8 with mem_rdata=0x0123..CDEF.
- LATENCY=1: read request in cycle 0 -> mem_ready in cycle 1. A request held continuously -> the next mem_ready in cycle 3.
- Aliasing, ADDR_W=8: write 0xAA..AA to addr 0x0000105, then read addr 0x0000005 -> returns 0xAA..AA.
- Abort: write 0x55..55 to addr 0x20, drop mem_write in cycle 3 -> no mem_ready. A later read of 0x20 returns the prior contents.
- Protocol errors: mem_read and mem_write high together -> proto_err=1 and the write commits. Changing mem_addr mid-WAIT -> proto_err stays 1 and the original address is used.
- Reset: assert proc_reset in cycle 4 of a write -> mem_ready=0 and proto_err=0 immediately. After reset, a read of that line returns the old data.
